// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Next-PC select encoding and default vector constants.
//  Revision : 1.0
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_EXC  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_RET  = 3'd4,
        SEL_SEQ  = 3'd5
    } pc_sel_e;

    localparam logic [31:0] c_DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] c_DEF_EXC_VEC   = 32'h8000_0180;
    localparam int          c_DEF_INC       = 4;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Redirect inputs and fetch-address outputs of the PC sequencer.
//  Revision : 1.0
// ============================================================================
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              Stall;
    logic              Exception;
    logic              BranchTaken;
    logic [ADDR_W-1:0] BranchTarget;
    logic              Jump;
    logic [ADDR_W-1:0] JumpTarget;
    logic              Call;
    logic [ADDR_W-1:0] LinkAddr;
    logic              Ret;
    logic [ADDR_W-1:0] PCResult;
    logic              PCValid;
    logic              RasEmpty;
    logic              RasFull;
    logic              RasOverflow;
    logic              RasUnderflow;

    // Upstream pipeline / hazard unit side.
    modport master (
        output Stall, Exception, BranchTaken, BranchTarget, Jump, JumpTarget,
               Call, LinkAddr, Ret,
        input  PCResult, PCValid, RasEmpty, RasFull, RasOverflow, RasUnderflow
    );

    // Sequencer side.
    modport slave (
        input  Stall, Exception, BranchTaken, BranchTarget, Jump, JumpTarget,
               Call, LinkAddr, Ret,
        output PCResult, PCValid, RasEmpty, RasFull, RasOverflow, RasUnderflow
    );

endinterface : pc_sequencer_if
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ras_stack
//  Purpose  : Circular return-address stack; a push when full drops the oldest.
//  Revision : 1.0
// ============================================================================
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_push,
    input  wire logic [ADDR_W-1:0] i_push_data,
    input  wire logic              i_pop,
    output      logic [ADDR_W-1:0] o_top,
    output      logic              o_empty,
    output      logic              o_full,
    output      logic              o_overflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [PTR_W-1:0]  w_push_ptr;

    // Writing one slot above the top lands on the oldest entry once full.
    assign w_push_ptr = r_top_ptr + PTR_W'(1);
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(RAS_DEPTH));
    assign o_top      = r_mem[r_top_ptr];
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_push_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top_ptr  <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_push) begin
            r_top_ptr <= w_push_ptr;
            if (o_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_top_ptr <= r_top_ptr - PTR_W'(1);
            r_count   <= r_count - CNT_W'(1);
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : IF-stage program counter with priority redirect and RAS.
//  Revision : 1.0
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(c_DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(c_DEF_EXC_VEC),
    parameter int                INC       = c_DEF_INC,
    parameter int                RAS_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pc_sequencer_if.slave      bus
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic              r_underflow;

    pc_sel_e           w_sel;
    logic              w_ret_empty;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_ras_overflow;

    always_comb begin
        w_sel       = SEL_SEQ;
        w_ret_empty = 1'b0;
        if (bus.Exception) begin
            w_sel = SEL_EXC;
        end else if (bus.Stall) begin
            w_sel = SEL_HOLD;
        end else if (bus.BranchTaken) begin
            w_sel = SEL_BR;
        end else if (bus.Jump) begin
            w_sel = SEL_JMP;
        end else if (bus.Ret) begin
            // A return with nothing stacked falls through to sequential fetch.
            if (w_ras_empty) begin
                w_ret_empty = 1'b1;
            end else begin
                w_sel = SEL_RET;
            end
        end
    end

    always_comb begin
        w_target = '0;
        case (w_sel)
            SEL_EXC:  w_target = EXC_VEC;
            SEL_BR:   w_target = bus.BranchTarget;
            SEL_JMP:  w_target = bus.JumpTarget;
            SEL_RET:  w_target = w_ras_top;
            default:  w_target = '0;
        endcase
    end

    always_comb begin
        case (w_sel)
            SEL_HOLD: w_next_pc = r_pc;
            SEL_SEQ:  w_next_pc = r_pc + ADDR_W'(INC);
            default:  w_next_pc = {w_target[ADDR_W-1:2], 2'b00};
        endcase
    end

    // The first edge out of reset only starts fetching at RESET_VEC.
    assign w_push = r_valid && (w_sel == SEL_JMP) && bus.Call;
    assign w_pop  = r_valid && (w_sel == SEL_RET);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (bus.LinkAddr),
        .i_pop       (w_pop),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full),
        .o_overflow  (w_ras_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VEC;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!r_valid) begin
            r_valid     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_underflow <= w_ret_empty;
        end
    end

    assign bus.PCResult     = r_pc;
    assign bus.PCValid      = r_valid;
    assign bus.RasEmpty     = w_ras_empty;
    assign bus.RasFull      = w_ras_full;
    assign bus.RasOverflow  = w_ras_overflow;
    assign bus.RasUnderflow = r_underflow;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench with a queue-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_pc_sequencer;
    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_EXC   = 32'h8000_0180;
    localparam logic [31:0] c_ALIGN = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0000),
        .EXC_VEC   (c_EXC),
        .INC       (4),
        .RAS_DEPTH (c_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: PC, valid flag and the RAS as a bounded queue.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] m_ras[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_ras.delete();
        end else begin
            m_unf = 1'b0;
            if (!m_valid) begin
                m_valid = 1'b1;
            end else if (bus.Exception) begin
                m_pc = c_EXC;
            end else if (bus.Stall) begin
                m_pc = m_pc;
            end else if (bus.BranchTaken) begin
                m_pc = bus.BranchTarget & c_ALIGN;
            end else if (bus.Jump) begin
                if (bus.Call) begin
                    if (m_ras.size() == c_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(bus.LinkAddr);
                end
                m_pc = bus.JumpTarget & c_ALIGN;
            end else if (bus.Ret && m_ras.size() > 0) begin
                m_pc = m_ras.pop_back() & c_ALIGN;
            end else begin
                if (bus.Ret) m_unf = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_pc",    bus.PCResult,            m_pc);
        check("model_valid", 32'(bus.PCValid),        32'(m_valid));
        check("model_empty", 32'(bus.RasEmpty),       32'(m_ras.size() == 0));
        check("model_full",  32'(bus.RasFull),        32'(m_ras.size() == c_DEPTH));
        check("model_ovf",   32'(bus.RasOverflow),    32'(m_ovf));
        check("model_unf",   32'(bus.RasUnderflow),   32'(m_unf));
    end

    task automatic idle();
        bus.Stall = 0; bus.Exception = 0; bus.BranchTaken = 0; bus.Jump = 0;
        bus.Call = 0; bus.Ret = 0;
        bus.BranchTarget = '0; bus.JumpTarget = '0; bus.LinkAddr = '0;
    endtask

    // Advance one cycle; inputs set before the call are sampled at its edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic call_to(input logic [31:0] tgt, input logic [31:0] link);
        idle(); bus.Jump = 1; bus.Call = 1; bus.JumpTarget = tgt; bus.LinkAddr = link;
        step();
        check("call_pc", bus.PCResult, tgt);
    endtask

    task automatic ret_to(input logic [31:0] exp);
        idle(); bus.Ret = 1;
        step();
        check("ret_pc", bus.PCResult, exp);
    endtask

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        idle();
        rst_n = 1'b0;
        step(); step();
        check("rst_pc",    bus.PCResult, 32'h0);
        check("rst_valid", 32'(bus.PCValid), 32'h0);
        check("rst_empty", 32'(bus.RasEmpty), 32'h1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("seq_pc", bus.PCResult, 32'(i * 4));
            check("seq_valid", 32'(bus.PCValid), 32'h1);
        end

        idle(); bus.BranchTaken = 1; bus.BranchTarget = 32'h8;
        step();
        check("br_to_8", bus.PCResult, 32'h8);
        bus.Stall = 1; bus.BranchTarget = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", bus.PCResult, 32'h8);
        end
        bus.Stall = 0;
        step();
        check("stall_release", bus.PCResult, 32'h40);
        idle();
        step();
        check("after_br", bus.PCResult, 32'h44);

        bus.BranchTaken = 1; bus.Jump = 1; bus.Exception = 1;
        bus.BranchTarget = 32'h500; bus.JumpTarget = 32'h600;
        step();
        check("exc_prio", bus.PCResult, c_EXC);
        idle(); bus.BranchTaken = 1; bus.BranchTarget = 32'h103;
        step();
        check("br_align", bus.PCResult, 32'h100);

        call_to(32'h200, 32'h10);
        call_to(32'h300, 32'h20);
        // Ret held during a stall and under an exception must not pop.
        idle(); bus.Ret = 1; bus.Stall = 1;
        step();
        check("stall_ret", bus.PCResult, 32'h300);
        ret_to(32'h20);
        ret_to(32'h10);
        check("ras_empty", 32'(bus.RasEmpty), 32'h1);

        for (int i = 1; i <= 5; i++) call_to(32'h400 + 32'(i * 16), 32'(i * 16));
        check("ras_full", 32'(bus.RasFull), 32'h1);
        check("ras_ovf",  32'(bus.RasOverflow), 32'h1);
        ret_to(32'h50);
        ret_to(32'h40);
        ret_to(32'h30);
        ret_to(32'h20);
        ret_to(32'h24);
        check("unf_pulse", 32'(bus.RasUnderflow), 32'h1);
        idle();
        step();
        check("unf_clear", 32'(bus.RasUnderflow), 32'h0);
        check("ovf_sticky", 32'(bus.RasOverflow), 32'h1);

        call_to(32'h100, 32'h60);
        call_to(32'h200, 32'h70);
        call_to(32'h300, 32'h80);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc",    bus.PCResult, 32'h0);
        check("async_empty", 32'(bus.RasEmpty), 32'h1);
        check("async_ovf",   32'(bus.RasOverflow), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("restart_pc", bus.PCResult, 32'h0);
        bus.BranchTaken = 1; bus.BranchTarget = 32'hFFFF_FFF8;
        step();
        check("wrap_a", bus.PCResult, 32'hFFFF_FFF8);
        idle();
        step();
        check("wrap_b", bus.PCResult, 32'hFFFF_FFFC);
        step();
        check("wrap_c", bus.PCResult, 32'h0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the IF stage of the MIPS pipeline.
- Produces the fetch address each cycle with stall, branch, jump, exception-vector redirect and a small circular return-address stack (RAS) for call/return prediction.
- Feeds instruction memory; redirect inputs come from the ID/EX stages and the hazard unit.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h8000_0180, PC value loaded on exception.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold current PC.
- Exception  in  1  redirect to EXC_VEC.
- BranchTaken  in  1  redirect to BranchTarget.
- BranchTarget  in  ADDR_W  branch destination.
- Jump  in  1  redirect to JumpTarget.
- JumpTarget  in  ADDR_W  jump/call destination.
- Call  in  1  with Jump: push LinkAddr onto RAS.
- LinkAddr  in  ADDR_W  return address to push.
- Ret  in  1  redirect to RAS top and pop.
- PCResult  out  ADDR_W  current fetch address.
- PCValid  out  1  PCResult is a real fetch.
- RasEmpty  out  1  RAS holds 0 entries.
- RasFull  out  1  RAS holds RAS_DEPTH entries.
- RasOverflow  out  1  sticky: a push overwrote an entry.
- RasUnderflow  out  1  one-cycle pulse: Ret issued while empty.

Behaviour:
- Reset (Reset=0, asynchronous): PCResult=RESET_VEC, PCValid=0, RAS count=0, RasEmpty=1, RasFull=0, RasOverflow=0, RasUnderflow=0. Reset mid-operation discards all RAS contents immediately.
- PCValid rises at the first Clk edge after Reset deasserts and stays 1.
- Single-cycle latency: the next-PC choice made from the inputs sampled at edge N appears on PCResult after edge N.
- Next-PC priority, highest first:
  1. Exception → EXC_VEC.
  2. Stall → hold PCResult.
  3. BranchTaken → BranchTarget.
  4. Jump → JumpTarget.
  5. Ret → RAS top.
  6. Otherwise → PCResult+INC.
- Exception overrides Stall. While stalled, all redirect, Call and Ret inputs are ignored with no RAS change; upstream holds them until Stall drops.
- All targets have bits [1:0] forced to 0 before loading. Addition wraps modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 = 0.
- RAS push happens only when Jump=1, Call=1 and the jump is the winning source.
  - Not full: write LinkAddr at top, count+1.
  - Full: circular overwrite of the oldest entry, count stays RAS_DEPTH, RasOverflow set (sticky until reset).
- RAS pop happens only when Ret is the winning source.
  - Not empty: PC=top, count-1.
  - Empty: PC=PCResult+INC, RasUnderflow pulses for 1 cycle, no state change.
- A Ret that loses to a higher-priority source is ignored, with no pop.
- Exception does not alter the RAS.
- Call without Jump is ignored.
- RasEmpty and RasFull are combinational from the registered count.

Decomposition:
- Shared package pc_pkg: next-PC select encoding (SEL_EXC, SEL_HOLD, SEL_BR, SEL_JMP, SEL_RET, SEL_SEQ) and the default RESET_VEC, EXC_VEC and INC constants.
- One sub-module, ras_stack, parametrised by ADDR_W and RAS_DEPTH: circular storage, top pointer, count, push/pop, overflow.
- pc_sequencer holds the priority mux and the PC register.

Test Plan:
- Reset low for 2 cycles, then release → PCResult=0 and PCValid=0 during reset; on successive edges PCResult=0, 4, 8, 12, 16, 20 with PCValid=1 from the first edge.
- PC=8, Stall=1 for 3 cycles with BranchTaken=1 and target 0x40 → PC holds at 8. Release Stall with BranchTaken still 1 → PC=0x40, then 0x44.
- BranchTaken, Jump and Exception all asserted in the same cycle → PC=0x80000180. Next cycle with only BranchTaken=1 and target 0x103 → PC=0x100.
- Call/Jump to 0x200 with LinkAddr 0x10, then Call/Jump to 0x300 with LinkAddr 0x20, then Ret, Ret → PC=0x200, 0x300, 0x20, 0x10; RasEmpty=1 afterwards.
- 5 calls with RAS_DEPTH=4 and LinkAddr 0x10..0x50 → RasFull=1 and RasOverflow=1. 4 Rets → PC=0x50, 0x40, 0x30, 0x20. A 5th Ret → sequential PC and a RasUnderflow pulse.
- Reset asserted while RAS holds 3 entries and PC=0x300 → PC=0 and RasEmpty=1 immediately without a clock edge; RasOverflow cleared. Sequence 32'hFFFF_FFF8 → FFFF_FFFC → 0 wraps.
